// File: rtl/spi_master_multi_pkg.sv
// Shared types for the SPI master slice.
//   spi_state_e : frame sequencer states
//   spi_mode_t  : per-frame mode bits captured at accept
//   spi_edge_w  : width of the SCK toggle counter for a given frame width
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      XFER  = 2'd2,
      HOLD  = 2'd3
   } spi_state_e;

   typedef struct packed {
      logic cpol;
      logic cpha;
      logic lsb_first;
   } spi_mode_t;

   // Counter must hold 0..2*DATA_W toggles.
   function automatic int spi_edge_w(input int data_w);
      return $clog2(2 * data_w + 1);
   endfunction

   localparam int SPI_EDGE_W_DEF = $clog2(2 * 8 + 1);

endpackage

// File: rtl/spi_master_multi_edge_gen.sv
// SCK timing generator: divides CLK by the latched half period and counts toggles.
//   clk, rst : system clock, synchronous active-high reset
//   en       : divider runs (any non-idle state); held at zero otherwise
//   act      : toggles are being produced (SETUP/XFER)
//   start    : frame accepted; restarts the toggle count
//   h        : half period in CLK cycles (never 0)
//   tick     : last cycle of the current half period
//   lead     : tick that registers a leading (odd) toggle
//   trail    : tick that registers a trailing (even) toggle
//   last     : tick that registers the final toggle of the frame
module spi_edge_gen #(
   parameter int DATA_W = 8,
   parameter int DIV_W  = 8,
   parameter int EW     = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             act,
   input  logic             start,
   input  logic [DIV_W-1:0] h,
   output logic             tick,
   output logic             lead,
   output logic             trail,
   output logic             last
);

   localparam logic [EW-1:0] LAST_E = EW'(2 * DATA_W - 1);

   logic [DIV_W-1:0] div_cnt;
   logic [EW-1:0]    edge_cnt;   // toggles already issued in this frame

   assign tick  = en && (div_cnt == h - DIV_W'(1));
   assign lead  = tick && act && !edge_cnt[0];
   assign trail = tick && act &&  edge_cnt[0];
   assign last  = trail && (edge_cnt == LAST_E);

   always_ff @(posedge clk) begin
      if (rst || !en || tick)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + DIV_W'(1);

      // start wins over the final toggle so a burst frame restarts at zero
      if (rst || start)
         edge_cnt <= '0;
      else if (tick && act)
         edge_cnt <= edge_cnt + EW'(1);
   end

endmodule

// File: rtl/spi_master_multi.sv
// SPI master with runtime mode/divider, one-hot active-low selects and burst support.
//   CLK, RST         : system clock, synchronous active-high reset
//   CPOL/CPHA/LSB_FIRST, DIV, CS_SEL : frame settings, captured at accept
//   TX_VALID/TX_READY/TX_DATA        : frame handshake and payload
//   MISO / SCK, MOSI, CS_N           : serial interface
//   RX_DATA, RX_VALID                : received word and its one-cycle strobe
//   BUSY                             : any state other than IDLE
module spi_master_multi
   import spi_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int NUM_CS = 4,
   parameter int DIV_W  = 8
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      CPOL,
   input  logic                      CPHA,
   input  logic                      LSB_FIRST,
   input  logic [DIV_W-1:0]          DIV,
   input  logic [$clog2(NUM_CS)-1:0] CS_SEL,
   input  logic                      TX_VALID,
   output logic                      TX_READY,
   input  logic [DATA_W-1:0]         TX_DATA,
   input  logic                      MISO,
   output logic                      SCK,
   output logic                      MOSI,
   output logic [NUM_CS-1:0]         CS_N,
   output logic [DATA_W-1:0]         RX_DATA,
   output logic                      RX_VALID,
   output logic                      BUSY
);

   localparam int EW  = spi_edge_w(DATA_W);
   localparam int CSW = $clog2(NUM_CS);

   spi_state_e          state;
   spi_mode_t           mode;
   logic [DIV_W-1:0]    h;
   logic [CSW-1:0]      cs_lat;
   logic [DATA_W-1:0]   tx_sh, rx_sh, rx_nxt;
   logic                samp_p, samp_lsb, fin_p;
   logic                tick, lead, trail, last;
   logic                act, acc, shift_ev, samp_ev;

   function automatic logic first_bit(input logic [DATA_W-1:0] x, input logic lsb);
      return lsb ? x[0] : x[DATA_W-1];
   endfunction

   function automatic logic [DATA_W-1:0] drop_bit(input logic [DATA_W-1:0] x, input logic lsb);
      return lsb ? (x >> 1) : (x << 1);
   endfunction

   assign act = (state == SETUP) || (state == XFER);

   spi_edge_gen #(.DATA_W(DATA_W), .DIV_W(DIV_W), .EW(EW)) u_edge (
      .clk   (CLK),
      .rst   (RST),
      .en    (state != IDLE),
      .act   (act),
      .start (acc),
      .h     (h),
      .tick  (tick),
      .lead  (lead),
      .trail (trail),
      .last  (last)
   );

   // Burst window: the cycle that registers the final toggle, same slave only.
   assign TX_READY = !RST && ((state == IDLE) || (state == XFER && last && CS_SEL == cs_lat));
   assign acc      = TX_VALID && TX_READY;
   assign BUSY     = (state != IDLE);

   assign shift_ev = mode.cpha ? lead : (trail && !last);
   assign samp_ev  = mode.cpha ? trail : lead;

   // MISO is taken in the cycle SCK shows the sampling edge; the bit order is
   // remembered with the strobe because a burst accept may re-latch LSB_FIRST.
   assign rx_nxt = samp_lsb ? {MISO, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], MISO};

   always_comb begin
      CS_N = '1;
      if (state != IDLE) CS_N[cs_lat] = 1'b0;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= IDLE;
         mode     <= '0;
         h        <= DIV_W'(1);
         cs_lat   <= '0;
         tx_sh    <= '0;
         rx_sh    <= '0;
         SCK      <= 1'b0;
         MOSI     <= 1'b0;
         RX_DATA  <= '0;
         RX_VALID <= 1'b0;
         samp_p   <= 1'b0;
         samp_lsb <= 1'b0;
         fin_p    <= 1'b0;
      end else begin
         samp_p   <= samp_ev;
         samp_lsb <= mode.lsb_first;
         fin_p    <= last;
         RX_VALID <= fin_p;

         if (samp_p) rx_sh <= rx_nxt;
         if (fin_p)  RX_DATA <= samp_p ? rx_nxt : rx_sh;

         if (lead || trail) SCK <= ~SCK;

         if (shift_ev) begin
            MOSI  <= first_bit(tx_sh, mode.lsb_first);
            tx_sh <= drop_bit(tx_sh, mode.lsb_first);
         end

         case (state)
            SETUP:   if (tick) state <= XFER;
            XFER:    if (last) state <= HOLD;
            HOLD:    if (tick) begin
                        state <= IDLE;
                        MOSI  <= 1'b0;
                     end
            default: ;
         endcase

         if (acc) begin
            state  <= (state == IDLE) ? SETUP : XFER;
            mode   <= '{cpol: CPOL, cpha: CPHA, lsb_first: LSB_FIRST};
            h      <= (DIV == '0) ? DIV_W'(1) : DIV;
            cs_lat <= CS_SEL;
            SCK    <= CPOL;
            // CPHA=0 presents the first bit before the first edge
            if (!CPHA) begin
               MOSI  <= first_bit(TX_DATA, LSB_FIRST);
               tx_sh <= drop_bit(TX_DATA, LSB_FIRST);
            end else begin
               tx_sh <= TX_DATA;
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_master_multi.sv
// Bench for spi_master_multi: timing model computed from frame accept cycle and
// half period, slave/loopback MISO, directed cases and randomized frames.
module tb_spi_master_multi;

   localparam int D   = 8;
   localparam int NCS = 4;

   logic       CLK = 1'b0, RST = 1'b1;
   logic       CPOL = 1'b0, CPHA = 1'b0, LSB_FIRST = 1'b0;
   logic [7:0] DIV = 8'd1;
   logic [1:0] CS_SEL = 2'd0;
   logic       TX_VALID = 1'b0;
   logic       TX_READY;
   logic [7:0] TX_DATA = 8'h00;
   logic       MISO, SCK, MOSI, RX_VALID, BUSY;
   logic [3:0] CS_N;
   logic [7:0] RX_DATA;

   bit         loop = 1'b1;
   logic       miso_slv = 1'b0;
   logic [7:0] slave_word = 8'h00;
   assign MISO = loop ? MOSI : miso_slv;

   spi_master_multi #(.DATA_W(D), .NUM_CS(NCS), .DIV_W(8)) dut (
      .CLK(CLK), .RST(RST), .CPOL(CPOL), .CPHA(CPHA), .LSB_FIRST(LSB_FIRST),
      .DIV(DIV), .CS_SEL(CS_SEL), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
      .TX_DATA(TX_DATA), .MISO(MISO), .SCK(SCK), .MOSI(MOSI), .CS_N(CS_N),
      .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      int t; int h; int cs;
      logic cpol, cpha, lsb;
      logic [7:0] d, rxw;
   } frm_t;
   typedef struct { int c; logic [7:0] w; } rxe_t;

   frm_t cur;
   bit   cur_v = 0;
   rxe_t rxq[$];
   logic [7:0] m_rx = 8'h00;
   bit   m_act = 0;
   int   m_k = 0;
   int   acc_cnt = 0, acc_c = 0, rxv_c = 0, rxv_cnt = 0, sck_rise = 0;
   logic [7:0] rx_last = 8'h00;
   logic [3:0] cs34 = 4'h0, cs35 = 4'h0;
   logic sck_prev = 1'b0;

   always @(negedge CLK) begin
      int c, s, k, n, h;
      bit act, def, e_rdy, e_rxv;
      logic e_sck, e_mosi;
      logic [3:0] e_cs;
      c = cyc; s = 0; k = 0; n = 0; act = 0; def = 1; e_mosi = 1'b0;
      if (cur_v) begin
         s = cur.t + 1;
         k = (c - s) / cur.h;
         if (k > 2*D) k = 2*D;
         act = (c < s + (2*D+1)*cur.h);
      end
      if (act) begin
         if (!cur.cpha) begin
            n = k / 2; if (n > D-1) n = D-1;
         end else if (k == 0) begin
            def = 0;
         end else begin
            n = (k - 1) / 2;
         end
         e_mosi   = cur.d[cur.lsb ? n : D-1-n];
         miso_slv = def ? cur.rxw[cur.lsb ? n : D-1-n] : 1'b0;
      end else begin
         miso_slv = 1'b0;
      end
      e_cs  = act ? ~(4'b0001 << cur.cs) : 4'b1111;
      e_sck = cur_v ? (cur.cpol ^ k[0]) : 1'b0;
      e_rdy = !RST && (!act || (c == s + 2*D*cur.h - 1 && int'(CS_SEL) == cur.cs));
      e_rxv = (rxq.size() > 0) && (rxq[0].c == c);
      if (e_rxv) begin m_rx = rxq[0].w; void'(rxq.pop_front()); end
      m_act = act; m_k = k;

      chk("busy",     BUSY,     act);
      chk("cs_n",     CS_N,     e_cs);
      chk("sck",      SCK,      e_sck);
      chk("tx_ready", TX_READY, e_rdy);
      chk("rx_valid", RX_VALID, e_rxv);
      chk("rx_data",  RX_DATA,  m_rx);
      if (def) chk("mosi", MOSI, e_mosi);

      // observations for the hand-computed checks
      if (RX_VALID === 1'b1) begin rxv_c = c; rxv_cnt++; rx_last = RX_DATA; end
      if (SCK === 1'b1 && sck_prev === 1'b0) sck_rise++;
      sck_prev = SCK;
      if (c == acc_c + 34) cs34 = CS_N;
      if (c == acc_c + 35) cs35 = CS_N;

      if (RST) begin
         cur_v = 0; rxq.delete(); m_rx = 8'h00;
      end else if (TX_VALID && e_rdy) begin
         h = (DIV == 8'd0) ? 1 : int'(DIV);
         cur = '{t: c, h: h, cs: int'(CS_SEL), cpol: CPOL, cpha: CPHA, lsb: LSB_FIRST,
                 d: TX_DATA, rxw: loop ? TX_DATA : slave_word};
         cur_v = 1;
         rxq.push_back('{c: c + 2 + 2*D*h, w: cur.rxw});
         acc_cnt++; acc_c = c; sck_rise = 0;
      end
   end

   // ---------------- driver helpers ----------------
   task automatic wait_acc();
      int n0 = acc_cnt;
      for (int i = 0; i < 10000; i++) begin
         @(posedge CLK); #1;
         if (acc_cnt != n0) return;
      end
      chk("accept_timeout", 1, 0);
   endtask

   task automatic wait_idle();
      repeat (2) @(posedge CLK);
      #1;
      for (int i = 0; i < 10000; i++) begin
         if (!m_act) return;
         @(posedge CLK); #1;
      end
      chk("idle_timeout", 1, 0);
   endtask

   task automatic frame(input logic pol, input logic pha, input logic lsb,
                        input logic [7:0] dv, input logic [1:0] cs, input logic [7:0] d);
      CPOL = pol; CPHA = pha; LSB_FIRST = lsb; DIV = dv; CS_SEL = cs; TX_DATA = d;
      TX_VALID = 1'b1; wait_acc(); TX_VALID = 1'b0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a1, a2, a3, a4, r0, m;
      repeat (3) @(posedge CLK);
      #1; RST = 1'b0;
      @(posedge CLK); #1;
      chk("rst_cs_n", CS_N, 4'hF);
      chk("rst_rx", RX_DATA, 8'h00);

      // 1: mode 0 loopback, H=2
      loop = 1; frame(0, 0, 0, 8'd2, 2'd0, 8'hA5); wait_idle();
      chk("t1_rx", rx_last, 8'hA5);
      chk("t1_rxv_lat", rxv_c - acc_c, 34);
      chk("t1_sck_pulses", sck_rise, 8);
      chk("t1_cs_t34", cs34, 4'b1110);
      chk("t1_cs_t35", cs35, 4'b1111);

      // 2: modes 1..3 against a slave returning 0x3C
      loop = 0; slave_word = 8'h3C;
      for (m = 1; m < 4; m++) begin
         frame(m[1], m[0], 0, 8'd3, 2'd1, 8'hC3); wait_idle();
         chk("t2_rx", rx_last, 8'h3C);
         chk("t2_idle_sck", SCK, m[1]);
      end

      // 3: LSB first
      loop = 1; frame(0, 0, 1, 8'd1, 2'd3, 8'h01); wait_idle();
      chk("t3_rx", rx_last, 8'h01);

      // 4: burst on select 2, then a select change forces HOLD
      r0 = rxv_cnt;
      CPOL = 0; CPHA = 0; LSB_FIRST = 0; DIV = 8'd1; CS_SEL = 2'd2;
      TX_DATA = 8'h11; TX_VALID = 1'b1; wait_acc(); a1 = acc_c;
      TX_DATA = 8'h22; wait_acc(); a2 = acc_c;
      TX_DATA = 8'h33; wait_acc(); a3 = acc_c;
      CS_SEL = 2'd1; TX_DATA = 8'h44; wait_acc(); a4 = acc_c;
      TX_VALID = 1'b0; wait_idle();
      chk("t4_gap12", a2 - a1, 16);
      chk("t4_gap23", a3 - a2, 16);
      chk("t4_gap34", a4 - a3, 18);
      chk("t4_rxv_cnt", rxv_cnt - r0, 4);
      chk("t4_rx_last", rx_last, 8'h44);

      // 5: reset after the fifth toggle
      frame(0, 1, 0, 8'd3, 2'd0, 8'h5A);
      for (int i = 0; i < 200 && m_k < 5; i++) begin @(posedge CLK); #1; end
      r0 = rxv_cnt;
      RST = 1'b1; @(posedge CLK); #1; RST = 1'b0;
      chk("t5_busy", BUSY, 1'b0);
      chk("t5_cs_n", CS_N, 4'hF);
      repeat (60) @(posedge CLK);
      #1;
      chk("t5_no_rxv", rxv_cnt - r0, 0);
      frame(1, 1, 1, 8'd2, 2'd2, 8'h96); wait_idle();
      chk("t5_rx", rx_last, 8'h96);

      // 6: DIV extremes; settings changed mid-frame are ignored
      frame(0, 0, 0, 8'd0, 2'd1, 8'h7E); wait_idle();
      chk("t6_div0_lat", rxv_c - acc_c, 18);
      frame(0, 0, 0, 8'd255, 2'd0, 8'hE7);
      CPOL = 1'b1; DIV = 8'd1; CS_SEL = 2'd3;
      wait_idle();
      chk("t6_div255_lat", rxv_c - acc_c, 2 + 16*255);
      chk("t6_idle_sck", SCK, 1'b0);
      chk("t6_rx", rx_last, 8'hE7);

      // randomized loopback bursts, one block per CPHA
      loop = 1;
      for (int b = 0; b < 2; b++) begin
         CPHA = 1'(b); CS_SEL = 2'($urandom_range(0, 3));
         for (int i = 0; i < 40; i++) begin
            CPOL = 1'($urandom_range(0, 1)); LSB_FIRST = 1'($urandom_range(0, 1));
            DIV = 8'($urandom_range(0, 4)); TX_DATA = 8'($urandom);
            if ($urandom_range(0, 5) == 0) CS_SEL = 2'($urandom_range(0, 3));
            TX_VALID = 1'b1; wait_acc();
            if ($urandom_range(0, 3) == 0) begin
               TX_VALID = 1'b0;
               repeat ($urandom_range(1, 30)) @(posedge CLK);
               #1;
            end
         end
         TX_VALID = 1'b0; wait_idle();
      end

      // randomized single frames against the slave, settings toggled while busy
      loop = 0;
      for (int i = 0; i < 40; i++) begin
         slave_word = 8'($urandom);
         CPOL = 1'($urandom_range(0, 1)); CPHA = 1'($urandom_range(0, 1));
         LSB_FIRST = 1'($urandom_range(0, 1)); DIV = 8'($urandom_range(0, 5));
         CS_SEL = 2'($urandom_range(0, 3)); TX_DATA = 8'($urandom);
         TX_VALID = 1'b1; wait_acc(); TX_VALID = 1'b0;
         CPOL = 1'($urandom_range(0, 1)); CPHA = 1'($urandom_range(0, 1));
         DIV = 8'($urandom); CS_SEL = 2'($urandom_range(0, 3)); slave_word = 8'($urandom);
         wait_idle();
         repeat ($urandom_range(0, 3)) @(posedge CLK);
         #1;
      end

      repeat (4) @(posedge CLK);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
